// File: rtl/tetris_pkg.sv
// Shared Tetris tile-grid definitions: tile type codes, default screen/grid
// geometry and the background colour used outside the grid window.
package tetris_pkg;

  typedef enum logic [3:0] {
    TILE_AIR    = 4'd0,
    TILE_I      = 4'd1,
    TILE_J      = 4'd2,
    TILE_L      = 4'd3,
    TILE_O      = 4'd4,
    TILE_S      = 4'd5,
    TILE_T      = 4'd6,
    TILE_Z      = 4'd7,
    TILE_BORDER = 4'd8
  } tile_type_e;

  localparam int DEF_NUM_TYPES = 9;
  localparam int DEF_H_ACTIVE  = 640;
  localparam int DEF_V_ACTIVE  = 480;
  localparam int DEF_TILE_PX   = 24;
  localparam int DEF_GRID_COLS = 12;
  localparam int DEF_GRID_ROWS = 20;
  localparam int DEF_GRID_X0   = 176;
  localparam int DEF_GRID_Y0   = 0;
  localparam logic [7:0] DEF_BG_RGB = 8'h00;

  // Codes beyond the ROM contents render as empty space.
  function automatic logic [3:0] type_or_air(input logic [3:0] t, input int num_types);
    if (int'(t) < num_types) return t;
    else return 4'(TILE_AIR);
  endfunction

endpackage

// File: rtl/tile_grid_renderer_axis.sv
// One screen axis: position counter plus incrementally maintained tile index
// and in-tile offset, so no divider is needed to locate the current tile.
module axis_tile_counter #(
  parameter int POS_W   = 10,
  parameter int IDX_W   = 5,
  parameter int OFF_W   = 5,
  parameter int POS_MAX = 639
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_step,
  input  logic             i_clear,
  input  logic [POS_W-1:0] i_start,
  input  logic [OFF_W-1:0] i_tile_px,
  input  logic [IDX_W-1:0] i_tile_cnt,
  output logic             o_in_window,
  output logic [IDX_W-1:0] o_idx,
  output logic [OFF_W-1:0] o_off
);

  logic [POS_W-1:0] r_pos;
  logic [IDX_W-1:0] r_idx;
  logic [OFF_W-1:0] r_off;
  logic [POS_W:0]   w_end;
  logic             w_in;

  assign w_end = (POS_W+1)'(i_start) + (POS_W+1)'(i_tile_cnt) * (POS_W+1)'(i_tile_px);
  assign w_in  = ({1'b0, r_pos} >= {1'b0, i_start}) && ({1'b0, r_pos} < w_end);

  // Index and offset only advance while the position lies inside the window.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_pos <= '0;
      r_idx <= '0;
      r_off <= '0;
    end else if (i_step && (r_pos != POS_W'(POS_MAX))) begin
      r_pos <= r_pos + POS_W'(1);
      if (w_in) begin
        if (r_off == i_tile_px - OFF_W'(1)) begin
          r_off <= '0;
          if (r_idx != i_tile_cnt - IDX_W'(1)) r_idx <= r_idx + IDX_W'(1);
        end else begin
          r_off <= r_off + OFF_W'(1);
        end
      end
    end
  end

  assign o_in_window = w_in;
  assign o_idx       = r_idx;
  assign o_off       = r_off;

endmodule

// File: rtl/tile_grid_renderer.sv
// Three-stage tile-grid to pixel renderer on a px_tick-enabled system clock.
// Optional blinking of flagged tiles: define TILE_GRID_RENDERER_BLINK_EN.
module tile_grid_renderer
  import tetris_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int TILE_PX   = DEF_TILE_PX,
  parameter int GRID_COLS = DEF_GRID_COLS,
  parameter int GRID_ROWS = DEF_GRID_ROWS,
  parameter int GRID_X0   = DEF_GRID_X0,
  parameter int GRID_Y0   = DEF_GRID_Y0,
  parameter int NUM_TYPES = DEF_NUM_TYPES,
  parameter logic [7:0] BG_RGB = DEF_BG_RGB,
  parameter int GRID_AW   = 8,
  parameter int TILE_AW   = 13
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               px_tick,
  input  logic               de,
  input  logic               vsync,
  output logic [GRID_AW-1:0] grid_addr,
  input  logic [7:0]         grid_data,
  output logic [TILE_AW-1:0] tile_addr,
  input  logic [7:0]         tile_data,
  output logic [7:0]         pixel_rgb,
  output logic               pixel_valid
);

  localparam int X_W   = $clog2(H_ACTIVE);
  localparam int Y_W   = $clog2(V_ACTIVE);
  localparam int COL_W = $clog2(GRID_COLS + 1);
  localparam int ROW_W = $clog2(GRID_ROWS + 1);
  localparam int OFF_W = $clog2(TILE_PX + 1);

  logic               r_de_prev, r_x_arm;
  logic               w_step_x, w_clear_x, w_step_y;
  logic               w_in_x, w_in_y;
  logic [COL_W-1:0]   w_col;
  logic [ROW_W-1:0]   w_row;
  logic [OFF_W-1:0]   w_xoff, w_yoff;
  logic [GRID_AW-1:0] w_grid_addr, r_grid_addr;
  logic               r_s0_de, r_s0_in;
  logic [OFF_W-1:0]   r_s0_xoff, r_s0_yoff;
  logic [3:0]         w_type;
  logic [TILE_AW-1:0] w_tile_addr, r_tile_addr;
  logic               r_s1_de, r_s1_in;
  logic               w_blank;
  logic [7:0]         w_pix, r_pixel_rgb;
  logic               r_pixel_valid;
  logic               w_unused_data;

  // x only counts once a blank tick has been seen, so a reset mid-line waits for the next line.
  assign w_step_x  = px_tick & de & r_x_arm;
  assign w_clear_x = px_tick & ~de;
  assign w_step_y  = r_de_prev & ~de;

  // Line-edge detector and x arming run on every clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_de_prev <= 1'b0;
      r_x_arm   <= 1'b0;
    end else begin
      r_de_prev <= de;
      if (w_clear_x) r_x_arm <= 1'b1;
    end
  end

  axis_tile_counter #(.POS_W(X_W), .IDX_W(COL_W), .OFF_W(OFF_W), .POS_MAX(H_ACTIVE - 1)) u_axis_x (
    .clk(clk), .reset(reset), .i_step(w_step_x), .i_clear(w_clear_x),
    .i_start(X_W'(GRID_X0)), .i_tile_px(OFF_W'(TILE_PX)), .i_tile_cnt(COL_W'(GRID_COLS)),
    .o_in_window(w_in_x), .o_idx(w_col), .o_off(w_xoff)
  );

  axis_tile_counter #(.POS_W(Y_W), .IDX_W(ROW_W), .OFF_W(OFF_W), .POS_MAX(V_ACTIVE - 1)) u_axis_y (
    .clk(clk), .reset(reset), .i_step(w_step_y), .i_clear(vsync),
    .i_start(Y_W'(GRID_Y0)), .i_tile_px(OFF_W'(TILE_PX)), .i_tile_cnt(ROW_W'(GRID_ROWS)),
    .o_in_window(w_in_y), .o_idx(w_row), .o_off(w_yoff)
  );

  assign w_grid_addr = GRID_AW'(int'(w_row) * GRID_COLS + int'(w_col));

  // Stage 0: grid RAM address plus the position context that travels with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s0_de     <= 1'b0;
      r_s0_in     <= 1'b0;
      r_s0_xoff   <= '0;
      r_s0_yoff   <= '0;
      r_grid_addr <= '0;
    end else if (px_tick) begin
      r_s0_de     <= de;
      r_s0_in     <= w_in_x & w_in_y;
      r_s0_xoff   <= w_xoff;
      r_s0_yoff   <= w_yoff;
      r_grid_addr <= de ? w_grid_addr : '0;
    end
  end

  assign w_type      = type_or_air(grid_data[3:0], NUM_TYPES);
  assign w_tile_addr = TILE_AW'(int'(w_type) * TILE_PX * TILE_PX
                                + int'(r_s0_yoff) * TILE_PX + int'(r_s0_xoff));

  // Stage 1: tile ROM address.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_de     <= 1'b0;
      r_s1_in     <= 1'b0;
      r_tile_addr <= '0;
    end else if (px_tick) begin
      r_s1_de     <= r_s0_de;
      r_s1_in     <= r_s0_in;
      r_tile_addr <= r_s0_de ? w_tile_addr : '0;
    end
  end

`ifdef TILE_GRID_RENDERER_BLINK_EN
  logic       r_s1_flag, r_vs_prev;
  logic [7:0] r_frame_cnt;

  // Blink flag follows its tile type; frames are counted on vsync rising edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_flag   <= 1'b0;
      r_vs_prev   <= 1'b0;
      r_frame_cnt <= 8'h00;
    end else begin
      r_vs_prev <= vsync;
      if (vsync && !r_vs_prev) r_frame_cnt <= r_frame_cnt + 8'h01;
      if (px_tick) r_s1_flag <= r_s0_de & grid_data[4];
    end
  end

  assign w_blank       = r_s1_flag & r_frame_cnt[3];
  assign w_unused_data = ^grid_data[7:5];
`else
  assign w_blank       = 1'b0;
  assign w_unused_data = ^grid_data[7:4];
`endif

  always_comb begin
    w_pix = 8'h00;
    if (r_s1_de && r_s1_in && !w_blank) w_pix = tile_data;
    else if (r_s1_de) w_pix = BG_RGB;
    else w_pix = 8'h00;
  end

  // Stage 2: output pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pixel_rgb   <= 8'h00;
      r_pixel_valid <= 1'b0;
    end else if (px_tick) begin
      r_pixel_rgb   <= w_pix;
      r_pixel_valid <= r_s1_de;
    end
  end

  assign grid_addr   = r_grid_addr;
  assign tile_addr   = r_tile_addr;
  assign pixel_rgb   = r_pixel_rgb;
  assign pixel_valid = r_pixel_valid;

endmodule
